lru_ctrl_4way: RTL and testbench
================================

LRU_CTRL_4WAY -- requirements
Module: lru_ctrl_4way

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: idle cycles after each command pulse before cnt_in is trusted (legal range 1..7).
REQ-002 SHALL have port clk, input, 1, clock; reset, input, 1: reset is synchronous, active-high; clock is clk.
REQ-003 SHALL have port req_valid, input, 1: an access request is pending.
REQ-004 SHALL have port req_ready, output, 1: the controller accepts a request this cycle.
REQ-005 SHALL have port req_hit, input, 1: 1 = hit on req_way; 0 = miss, so the controller picks a victim.
REQ-006 SHALL have port req_way, input, 2: accessed way; ignored on a miss.
REQ-007 SHALL have port cnt_in, input, 8: {cnt3,cnt2,cnt1,cnt0} read back from four 2-bit counter registers.
REQ-008 SHALL have port ld, output, 4: per-way load pulse; the counter becomes 3 (MRU).
REQ-009 SHALL have port dcr, output, 4: per-way decrement pulse.
REQ-010 SHALL have port done_valid, output, 1: one-cycle completion strobe.
REQ-011 SHALL have port done_way, output, 2: the way promoted to MRU (the hit way or the victim).
REQ-012 SHALL have port err, output, 1: sticky flag; the snapshot was not a permutation of 0..3.

Function
REQ-013 SHALL implement the states INIT, IDLE, CMD, SETTLE and RESP.
REQ-014 INIT SHALL run four steps, i = 0..3.
- Each step asserts ld[i] and dcr[j] for all j<i for one cycle, then waits SETTLE_CYCLES.
- Result: counters {3,2,1,0} for ways 3..0.
REQ-015 req_ready SHALL be 1 only in IDLE.
REQ-016 A request SHALL be accepted when req_valid && req_ready; the accept cycle is T.
REQ-017 On accept, the controller SHALL capture req_hit, req_way and a snapshot of cnt_in.
REQ-018 Target selection:
- Target k = req_way on a hit.
- On a miss, k = the lowest-index way whose snapshot count is 0.
REQ-019 In CMD (cycle T+1), the controller SHALL assert ld[k] and dcr[j] for every j≠k whose snapshot count exceeds snapshot count[k], for exactly one cycle.
REQ-020 ld and dcr SHALL never both be asserted for the same way.
REQ-021 A hit on a way already at 3 SHALL pulse only ld[k]; all dcr bits stay 0.
REQ-022 After CMD, the controller SHALL stay in SETTLE for SETTLE_CYCLES cycles.
REQ-023 RESP SHALL assert done_valid with done_way = k for one cycle (T+2+SETTLE_CYCLES), then return to IDLE.
REQ-024 req_valid while req_ready=0 SHALL be ignored; the requester holds the request until accepted.
REQ-025 If the snapshot is not a permutation of 0..3, the controller SHALL:
- set err;
- on a miss with no zero count, take k = the lowest-index minimum;
- still complete the update.
REQ-026 ld and dcr SHALL be 0 in every state other than CMD and the INIT pulse cycles.

Reset
REQ-027 Reset SHALL be checked on the clk rising edge, before any other condition.
REQ-028 While reset=1, outputs SHALL be ld=0, dcr=0, req_ready=0, done_valid=0, done_way=0 and err=0.
REQ-029 Reset SHALL set the state to INIT step 0.
REQ-030 Reset asserted mid-operation (CMD, SETTLE, RESP or INIT) SHALL abort the operation with no done_valid; INIT SHALL rerun from step 0 after reset deasserts.

Structure
REQ-031 Package lru_pkg SHALL hold:
- the state enum;
- WAY_W=2, NWAYS=4;
- constants CNT_MRU=3 and CNT_LRU=0.
REQ-032 Sub-module lru_update_dec SHALL be combinational:
- inputs: snapshot, hit, way;
- outputs: target k, ld mask, dcr mask, permutation-error flag.
REQ-033 lru_ctrl_4way SHALL contain the FSM, the settle counter and the capture registers.

Verification
REQ-034 The bench SHALL wire the controller to four of the team's 2-bit LRU counter registers, with SETTLE_CYCLES=2.
REQ-035 Reset, then release -> four INIT steps complete, cnt_in = 8'hE4, req_ready rises, err=0.
REQ-036 From 8'hE4, miss -> ld=4'b0001 and dcr=4'b1110 in CMD; done_way=0 at T+4; cnt_in = 8'h93.
REQ-037 From 8'hE4, hit way 2 -> ld=4'b0100, dcr=4'b1000; done_way=2; cnt_in = 8'hB4.
REQ-038 From 8'hE4, hit way 3 -> ld=4'b1000, dcr=0; cnt_in unchanged at 8'hE4.
REQ-039 Force cnt_in = 8'h00, then miss -> err=1, done_way=0, dcr=4'b0000.
REQ-040 Reset pulsed during SETTLE -> no done_valid, INIT reruns, final cnt_in = 8'hE4.

Source files
------------

// File: rtl/lru_pkg.sv
// Shared types and constants for the 4-way LRU counter controller.
package lru_pkg;

   localparam int unsigned WAY_W  = 2;
   localparam int unsigned NWAYS  = 4;
   localparam int unsigned CNT_W  = 2;
   localparam int unsigned SNAP_W = NWAYS * CNT_W;
   localparam int unsigned WAIT_W = 3;
   localparam int unsigned STEP_W = 3;

   localparam logic [CNT_W-1:0] CNT_MRU = 2'd3;
   localparam logic [CNT_W-1:0] CNT_LRU = 2'd0;

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      CMD,
      SETTLE,
      RESP
   } state_t;

endpackage

// File: rtl/lru_ctrl_4way_dec.sv
// Combinational update decoder: picks the target way and the ld/dcr masks
// that promote it to MRU while ageing every way that was more recent.
module lru_update_dec
   import lru_pkg::*;
(
   input  logic [SNAP_W-1:0] snap,
   input  logic              hit,
   input  logic [WAY_W-1:0]  way,
   output logic [WAY_W-1:0]  k,
   output logic [NWAYS-1:0]  ld_mask,
   output logic [NWAYS-1:0]  dcr_mask,
   output logic              perr
);

   logic [CNT_W-1:0] cnt [NWAYS];
   logic [NWAYS-1:0] seen;
   logic [CNT_W-1:0] min_cnt;
   logic [WAY_W-1:0] k_min;

   // Split the snapshot, flag non-permutations, find the lowest-index minimum
   // (which is the lowest zero whenever a zero exists), then build the masks.
   always_comb begin
      seen     = '0;
      min_cnt  = CNT_MRU;
      k_min    = WAY_W'(NWAYS - 1);
      ld_mask  = '0;
      dcr_mask = '0;
      for (int i = 0; i < NWAYS; i++) begin
         cnt[i] = snap[i*CNT_W +: CNT_W];
      end
      for (int i = 0; i < NWAYS; i++) begin
         seen[cnt[i]] = 1'b1;
      end
      for (int i = NWAYS - 1; i >= 0; i--) begin
         if (cnt[i] <= min_cnt) begin
            min_cnt = cnt[i];
            k_min   = WAY_W'(i);
         end
      end
      perr = (seen != '1);
      k    = hit ? way : k_min;
      ld_mask[k] = 1'b1;
      for (int j = 0; j < NWAYS; j++) begin
         dcr_mask[j] = (WAY_W'(j) != k) && (cnt[j] > cnt[k]);
      end
   end

endmodule

// File: rtl/lru_ctrl_4way.sv
// 4-way LRU controller: initialises four external 2-bit age counters, then
// serves hit/miss requests by pulsing per-way load/decrement commands.
module lru_ctrl_4way
   import lru_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_hit,
   input  logic [WAY_W-1:0]  req_way,
   input  logic [SNAP_W-1:0] cnt_in,
   output logic [NWAYS-1:0]  ld,
   output logic [NWAYS-1:0]  dcr,
   output logic              done_valid,
   output logic [WAY_W-1:0]  done_way,
   output logic              err
);

   state_t              state_q, state_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic [WAIT_W-1:0]   wcnt_q, wcnt_d;

   logic [SNAP_W-1:0]   snap_q;
   logic                hit_q;
   logic [WAY_W-1:0]    way_q;

   logic [NWAYS-1:0]    ld_d, dcr_d;
   logic                req_ready_d, done_valid_d, err_d;
   logic [WAY_W-1:0]    done_way_d;

   logic                accept;
   logic [SNAP_W-1:0]   dec_snap;
   logic                dec_hit;
   logic [WAY_W-1:0]    dec_way;
   logic [WAY_W-1:0]    dec_k;
   logic [NWAYS-1:0]    dec_ld, dec_dcr;
   logic                dec_perr;
   logic [NWAYS-1:0]    init_ld;

   assign accept = (state_q == IDLE) && req_valid && req_ready;

   // Decode live inputs while idle (commands issue the cycle after accept);
   // afterwards decode the captured request to report the promoted way.
   assign dec_snap = (state_q == IDLE) ? cnt_in  : snap_q;
   assign dec_hit  = (state_q == IDLE) ? req_hit : hit_q;
   assign dec_way  = (state_q == IDLE) ? req_way : way_q;

   // Init step i loads way i and ages every lower way.
   assign init_ld = NWAYS'(1) << step_q[WAY_W-1:0];

   lru_update_dec u_dec (
      .snap     (dec_snap),
      .hit      (dec_hit),
      .way      (dec_way),
      .k        (dec_k),
      .ld_mask  (dec_ld),
      .dcr_mask (dec_dcr),
      .perr     (dec_perr)
   );

   // State, sequencing counters and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= INIT;
         step_q     <= '0;
         wcnt_q     <= '0;
         ld         <= '0;
         dcr        <= '0;
         req_ready  <= 1'b0;
         done_valid <= 1'b0;
         done_way   <= '0;
         err        <= 1'b0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         wcnt_q     <= wcnt_d;
         ld         <= ld_d;
         dcr        <= dcr_d;
         req_ready  <= req_ready_d;
         done_valid <= done_valid_d;
         done_way   <= done_way_d;
         err        <= err_d;
      end
   end

   // Capture the accepted request and its counter snapshot.
   always_ff @(posedge clk) begin
      if (reset) begin
         snap_q <= '0;
         hit_q  <= 1'b0;
         way_q  <= '0;
      end else if (accept) begin
         snap_q <= cnt_in;
         hit_q  <= req_hit;
         way_q  <= req_way;
      end
   end

   // Next-state logic; output values computed here appear in the next state.
   always_comb begin
      state_d      = state_q;
      step_d       = step_q;
      wcnt_d       = wcnt_q;
      ld_d         = '0;
      dcr_d        = '0;
      req_ready_d  = 1'b0;
      done_valid_d = 1'b0;
      done_way_d   = '0;
      err_d        = err;
      case (state_q)
         INIT: begin
            if (wcnt_q != '0) begin
               wcnt_d = wcnt_q - WAIT_W'(1);
            end else if (step_q == STEP_W'(NWAYS)) begin
               state_d     = IDLE;
               req_ready_d = 1'b1;
            end else begin
               ld_d   = init_ld;
               dcr_d  = init_ld - NWAYS'(1);
               step_d = step_q + STEP_W'(1);
               wcnt_d = WAIT_W'(SETTLE_CYCLES);
            end
         end
         IDLE: begin
            req_ready_d = 1'b1;
            if (accept) begin
               state_d     = CMD;
               req_ready_d = 1'b0;
               ld_d        = dec_ld;
               dcr_d       = dec_dcr;
               err_d       = err | dec_perr;
            end
         end
         CMD: begin
            state_d = SETTLE;
            wcnt_d  = WAIT_W'(SETTLE_CYCLES - 1);
         end
         SETTLE: begin
            if (wcnt_q == '0) begin
               state_d      = RESP;
               done_valid_d = 1'b1;
               done_way_d   = dec_k;
            end else begin
               wcnt_d = wcnt_q - WAIT_W'(1);
            end
         end
         RESP: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
         end
         default: begin
            state_d = INIT;
            step_d  = '0;
            wcnt_d  = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_lru_ctrl_4way.sv
// Directed bench: controller driving four 2-bit LRU counter registers.
module tb_lru_ctrl_4way;

   logic       clk;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic       req_hit;
   logic [1:0] req_way;
   logic [7:0] cnt_in;
   logic [3:0] ld;
   logic [3:0] dcr;
   logic       done_valid;
   logic [1:0] done_way;
   logic       err;

   logic [1:0] cnt [4];
   logic [7:0] cnt_bus;
   logic       force_zero;

   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0] init_ld_tab  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
   logic [3:0] init_dcr_tab [4] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111};

   lru_ctrl_4way #(.SETTLE_CYCLES(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_hit    (req_hit),
      .req_way    (req_way),
      .cnt_in     (cnt_in),
      .ld         (ld),
      .dcr        (dcr),
      .done_valid (done_valid),
      .done_way   (done_way),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Four 2-bit counter registers: load to MRU, else saturating decrement.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (ld[i])                      cnt[i] <= 2'd3;
         else if (dcr[i] && cnt[i] != 0) cnt[i] <= cnt[i] - 2'd1;
      end
   end

   assign cnt_bus = {cnt[3], cnt[2], cnt[1], cnt[0]};
   assign cnt_in  = force_zero ? 8'h00 : cnt_bus;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Wait for init to finish, checking each init pulse and the final state.
   task automatic init_seq();
      int pulses = 0;
      int dones  = 0;
      bit ready  = 1'b0;
      for (int c = 0; c < 200 && !ready; c++) begin
         @(posedge clk); #1;
         if (ld != 4'b0000) begin
            if (pulses < 4) begin
               check("init_ld",  32'(ld),  32'(init_ld_tab[pulses]));
               check("init_dcr", 32'(dcr), 32'(init_dcr_tab[pulses]));
            end
            pulses++;
         end
         if (done_valid) dones++;
         if (req_ready) ready = 1'b1;
      end
      check("init_ready",   32'(ready),   32'd1);
      check("init_pulses",  32'(pulses),  32'd4);
      check("init_no_done", 32'(dones),   32'd0);
      check("init_cnt",     32'(cnt_bus), 32'hE4);
      check("init_err",     32'(err),     32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      init_seq();
   endtask

   // Issue one request and follow it through CMD, SETTLE and RESP.
   task automatic run_req(input bit hit, input logic [1:0] way,
                          input logic [3:0] e_ld, input logic [3:0] e_dcr,
                          input logic [1:0] e_way, input logic [7:0] e_cnt,
                          input bit e_err);
      req_valid = 1'b1;
      req_hit   = hit;
      req_way   = way;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("cmd_ld",    32'(ld),        32'(e_ld));
      check("cmd_dcr",   32'(dcr),       32'(e_dcr));
      check("cmd_ready", 32'(req_ready), 32'd0);
      for (int c = 2; c <= 3; c++) begin
         @(posedge clk); #1;
         check("settle_done", 32'(done_valid), 32'd0);
         check("settle_cmd",  32'({ld, dcr}), 32'd0);
      end
      @(posedge clk); #1;
      check("resp_valid", 32'(done_valid), 32'd1);
      check("resp_way",   32'(done_way),   32'(e_way));
      check("resp_cnt",   32'(cnt_bus),    32'(e_cnt));
      check("resp_err",   32'(err),        32'(e_err));
      @(posedge clk); #1;
      check("back_ready", 32'(req_ready),  32'd1);
      check("back_done",  32'(done_valid), 32'd0);
   endtask

   initial begin
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_hit    = 1'b0;
      req_way    = 2'd0;
      force_zero = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ld",    32'(ld),         32'd0);
      check("rst_dcr",   32'(dcr),        32'd0);
      check("rst_ready", 32'(req_ready),  32'd0);
      check("rst_done",  32'(done_valid), 32'd0);
      check("rst_way",   32'(done_way),   32'd0);
      check("rst_err",   32'(err),        32'd0);
      reset = 1'b0;
      init_seq();

      // Miss from E4: way 0 is LRU, all others age.
      run_req(1'b0, 2'd0, 4'b0001, 4'b1110, 2'd0, 8'h93, 1'b0);

      // Hit way 2 from E4: only way 3 was more recent.
      do_reset();
      run_req(1'b1, 2'd2, 4'b0100, 4'b1000, 2'd2, 8'hB4, 1'b0);

      // Hit on the MRU way: load only, counters unchanged.
      do_reset();
      run_req(1'b1, 2'd3, 4'b1000, 4'b0000, 2'd3, 8'hE4, 1'b0);

      // Corrupt snapshot (all zero) on a miss: err, way 0, no decrements.
      // The real counters only see ld[0], so they become {3,2,1,3}.
      force_zero = 1'b1;
      run_req(1'b0, 2'd1, 4'b0001, 4'b0000, 2'd0, 8'hE7, 1'b1);
      force_zero = 1'b0;
      check("err_sticky", 32'(err), 32'd1);

      // Reset during SETTLE aborts without completion, then init reruns.
      do_reset();
      req_valid = 1'b1;
      req_hit   = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         check("abort_done",  32'(done_valid), 32'd0);
         check("abort_ready", 32'(req_ready),  32'd0);
      end
      reset = 1'b0;
      init_seq();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
